wb_gain_apply: RTL and testbench
================================

Name: wb_gain_apply

Overview:
Applies the white-balance gains bk and rk to the raw Bayer pixel stream. Those gains come from the gain-estimation block and are unsigned Q10.8, where 256 means unity. Blue pixels are scaled by bk, red pixels by rk, and both green phases pass through at unity. Gains are double-buffered so they change only on a frame boundary. The block sits in the pixel path downstream of the capture interface and in parallel with gain estimation.

Parameters:
DATA_W, 8, pixel width
GAIN_W, 18, gain width (unsigned, Q10.8)
GAIN_FRAC, 8, gain fractional bits; unity = 1<<GAIN_FRAC
CNT_W, 16, clipped-pixel counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
data_in_valid  in  1  input pixel valid
data_in  in  DATA_W  raw Bayer pixel
x  in  1  Bayer column phase
y  in  1  Bayer row phase
frame_start  in  1  one-cycle pulse coincident with the first pixel of a frame
bk  in  GAIN_W  blue gain from gain estimation
rk  in  GAIN_W  red gain from gain estimation
gain_load  in  1  one-cycle pulse; capture bk/rk as pending gains
data_out_valid  out  1  output pixel valid
data_out  out  DATA_W  gain-corrected pixel
x_out  out  1  x delayed to align with data_out
y_out  out  1  y delayed to align with data_out
gain_pending  out  1  pending gains are waiting for the next frame_start
clip_count  out  CNT_W  number of saturated pixels in the last completed frame

Behaviour:
- Reset (async, rst=1): all outputs go to 0.
  - Active gains and pending gains reset to 256 (unity).
  - All pipeline valids and the running clip counter clear.
  - Asserting rst mid-stream discards all in-flight pixels; no partial output follows.
- Colour select (same phase decode as gain estimation):
  - !x&!y → B, uses bk_act.
  - x&y → R, uses rk_act.
  - x^y → G0/G1, uses unity.
- Gain double-buffer:
  - gain_load captures bk and rk into the pending registers and sets gain_pending.
  - frame_start with gain_pending=1 copies pending to active and clears gain_pending.
  - The pixel presented on that same cycle already uses the new gains (stage 1 selects pending gains combinationally in that case).
  - frame_start with gain_pending=0 leaves the active gains unchanged.
  - gain_load and frame_start in the same cycle: any previously pending value is applied. The new value becomes pending and gain_pending stays 1.
  - Repeated gain_load before a frame_start: the last load wins.
- Pipeline: 3 stages, fixed latency of 3 clocks from data_in_valid to data_out_valid. There is no backpressure and every stage advances every cycle.
  - S1: register the pixel, selected gain (GAIN_W), x, y, valid, and a frame_start tag.
  - S2: product = pixel × gain, unsigned, DATA_W+GAIN_W = 26 bits.
  - S3: round and saturate.
    - r = (product + 2^(GAIN_FRAC-1)) >> GAIN_FRAC.
    - If r > 2^DATA_W−1, output 255 and flag a clip; otherwise output r[DATA_W-1:0].
  - Green pixels: output equals input exactly.
  - Gain 0: output is 0.
- data_out, x_out and y_out update only when the S3 valid is 1; otherwise they hold their last value.
- Clip statistics:
  - The running counter increments on each S3 valid clipped pixel and saturates at 2^CNT_W−1 (no wrap).
  - When the frame_start tag reaches S3, clip_count latches the running count, which covers the previous frame up to but excluding the tagged pixel.
  - On that same cycle the counter restarts at 0, or at 1 if the tagged pixel itself clips.
  - The first frame_start after reset publishes 0.
- Invalid cycles (data_in_valid=0) carry no pixel. frame_start still applies gains and still propagates its tag.

Decomposition:
- Shared package:
  - GAIN_UNITY = 256 and GAIN_FRAC = 8, also used by gain estimation so the Q10.8 format is defined once.
  - Bayer phase encodings B/G0/G1/R from {y,x}.
- One natural sub-module: wb_round_sat, the combinational round/saturate from 26 to 8 bits with a clip flag, instantiated in S3.
- The double-buffer and pipeline stay in the top.

Test Plan:
1. After reset, with no gain_load, stream B=100, G0=37, G1=200, R=255 → outputs 100, 37, 200, 255 exactly 3 cycles later, with x_out/y_out matching; clip_count=0.
2. gain_load with bk=512, rk=384, then frame_start with B=100 on the same cycle → B output 200. Next R=3 → 1152+128 = 1280 >> 8 = 5. Next R=200 → 300 → 255 (clipped).
3. gain_load without frame_start, then B=100 → output 100 (old unity gain); gain_pending=1. Next frame_start → gain_pending=0 and the new gain is used from that pixel onward.
4. gain_load(bk=768) and frame_start in the same cycle while bk=512 is pending → the pixel uses 512; gain_pending stays 1; bk=768 is applied at the following frame_start.
5. Frame of 10 B pixels at 200 with bk=512 → the next frame_start publishes clip_count=10. Force CNT_W=4 with 20 clipping pixels → publishes 15.
6. Assert rst while 3 pixels are in flight → data_out_valid stays 0, outputs read 0, and gains return to unity.

Source files
------------

// File: rtl/wb_gain_apply_pkg.sv
// Shared definitions for the white-balance path: Q10.8 gain format and Bayer phase decode.
package wb_gain_apply_pkg;

  localparam int unsigned GAIN_FRAC  = 8;
  localparam int unsigned GAIN_UNITY = 1 << GAIN_FRAC;

  // Encoded as {y, x}
  typedef enum logic [1:0] {
    PhB  = 2'b00,
    PhG0 = 2'b01,
    PhG1 = 2'b10,
    PhR  = 2'b11
  } bayer_ph_e;

  function automatic bayer_ph_e bayer_phase(input logic x, input logic y);
    return bayer_ph_e'({y, x});
  endfunction

endpackage

// File: rtl/wb_round_sat.sv
// Round-half-up a fixed-point product by FRAC bits and saturate to OUT_W bits.
module wb_round_sat #(
  parameter int unsigned IN_W  = 26,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned FRAC  = 8
) (
  input  logic [IN_W-1:0]  prod_i,
  output logic [OUT_W-1:0] pix_o,
  output logic             clip_o
);

  localparam logic [IN_W:0] Half = (IN_W + 1)'(1) << (FRAC - 1);

  logic [IN_W:0] sum;
  logic [IN_W:0] rounded;

  // Extra MSB keeps the rounding carry of a full-scale product.
  assign sum     = {1'b0, prod_i} + Half;
  assign rounded = sum >> FRAC;
  assign clip_o  = |rounded[IN_W:OUT_W];
  assign pix_o   = clip_o ? '1 : rounded[OUT_W-1:0];

endmodule

// File: rtl/wb_gain_apply.sv
// Applies double-buffered white-balance gains to a Bayer stream (3-stage pipeline)
// and publishes a per-frame count of saturated pixels.
module wb_gain_apply #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GAIN_W    = 18,
  parameter int unsigned GAIN_FRAC = wb_gain_apply_pkg::GAIN_FRAC,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              x,
  input  logic              y,
  input  logic              frame_start,
  input  logic [GAIN_W-1:0] bk,
  input  logic [GAIN_W-1:0] rk,
  input  logic              gain_load,
  output logic              data_out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              x_out,
  output logic              y_out,
  output logic              gain_pending,
  output logic [CNT_W-1:0]  clip_count
);
  import wb_gain_apply_pkg::*;

  localparam int unsigned       ProdW   = DATA_W + GAIN_W;
  localparam logic [GAIN_W-1:0] GainOne = GAIN_W'(1) << GAIN_FRAC;
  localparam logic [CNT_W-1:0]  CntMax  = '1;

  logic [GAIN_W-1:0] bk_act_q, rk_act_q, bk_pend_q, rk_pend_q;
  logic              pend_q;
  logic              apply_now;
  logic [GAIN_W-1:0] bk_use, rk_use, gain_sel;

  logic              s1_valid_q, s1_fs_q, s1_x_q, s1_y_q;
  logic [DATA_W-1:0] s1_pix_q;
  logic [GAIN_W-1:0] s1_gain_q;
  logic              s2_valid_q, s2_fs_q, s2_x_q, s2_y_q;
  logic [ProdW-1:0]  s2_prod_q;

  logic [DATA_W-1:0] sat_pix;
  logic              sat_clip, clip_hit;
  logic [CNT_W-1:0]  clip_run_q, clip_run_d, clip_count_q, clip_count_d;

  // A frame_start that retires pending gains must already steer the pixel on the same cycle.
  assign apply_now = frame_start & pend_q;
  assign bk_use    = apply_now ? bk_pend_q : bk_act_q;
  assign rk_use    = apply_now ? rk_pend_q : rk_act_q;

  always_comb begin
    gain_sel = GainOne;
    unique case (bayer_phase(x, y))
      PhB:        gain_sel = bk_use;
      PhR:        gain_sel = rk_use;
      PhG0, PhG1: gain_sel = GainOne;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bk_act_q  <= GainOne;
      rk_act_q  <= GainOne;
      bk_pend_q <= GainOne;
      rk_pend_q <= GainOne;
      pend_q    <= 1'b0;
    end else begin
      if (apply_now) begin
        bk_act_q <= bk_pend_q;
        rk_act_q <= rk_pend_q;
      end
      if (gain_load) begin
        bk_pend_q <= bk;
        rk_pend_q <= rk;
      end
      pend_q <= gain_load | (pend_q & ~frame_start);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fs_q    <= 1'b0;
      s1_x_q     <= 1'b0;
      s1_y_q     <= 1'b0;
      s1_pix_q   <= '0;
      s1_gain_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_fs_q    <= 1'b0;
      s2_x_q     <= 1'b0;
      s2_y_q     <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s1_valid_q <= data_in_valid;
      s1_fs_q    <= frame_start;
      s1_x_q     <= x;
      s1_y_q     <= y;
      s1_pix_q   <= data_in;
      s1_gain_q  <= gain_sel;
      s2_valid_q <= s1_valid_q;
      s2_fs_q    <= s1_fs_q;
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
      s2_prod_q  <= ProdW'(s1_pix_q) * ProdW'(s1_gain_q);
    end
  end

  wb_round_sat #(
    .IN_W  (ProdW),
    .OUT_W (DATA_W),
    .FRAC  (GAIN_FRAC)
  ) u_round_sat (
    .prod_i (s2_prod_q),
    .pix_o  (sat_pix),
    .clip_o (sat_clip)
  );

  assign clip_hit = s2_valid_q & sat_clip;

  // The tagged pixel belongs to the new frame, so it seeds the restarted counter.
  always_comb begin
    clip_run_d   = clip_run_q;
    clip_count_d = clip_count_q;
    if (s2_fs_q) begin
      clip_count_d = clip_run_q;
      clip_run_d   = clip_hit ? CNT_W'(1) : '0;
    end else if (clip_hit && clip_run_q != CntMax) begin
      clip_run_d = clip_run_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      x_out          <= 1'b0;
      y_out          <= 1'b0;
      clip_run_q     <= '0;
      clip_count_q   <= '0;
    end else begin
      data_out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        data_out <= sat_pix;
        x_out    <= s2_x_q;
        y_out    <= s2_y_q;
      end
      clip_run_q   <= clip_run_d;
      clip_count_q <= clip_count_d;
    end
  end

  assign gain_pending = pend_q;
  assign clip_count   = clip_count_q;

endmodule

// File: tb/tb_wb_gain_apply.sv
// Directed bench for wb_gain_apply; a second instance with a 4-bit clip counter covers saturation.
module tb_wb_gain_apply;

  localparam logic [1:0] PB = 2'b00, PG0 = 2'b01, PG1 = 2'b10, PR = 2'b11;  // {y, x}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in_valid, x, y, frame_start, gain_load;
  logic [7:0]  data_in;
  logic [17:0] bk, rk;

  logic        data_out_valid, x_out, y_out, gain_pending;
  logic [7:0]  data_out;
  logic [15:0] clip_count;
  logic        s_valid, s_x, s_y, s_pend;
  logic [7:0]  s_data;
  logic [3:0]  s_clip;

  logic        ev[3];
  logic [7:0]  ed[3];
  logic [1:0]  ep[3];

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  wb_gain_apply u_dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .x              (x),
    .y              (y),
    .frame_start    (frame_start),
    .bk             (bk),
    .rk             (rk),
    .gain_load      (gain_load),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .x_out          (x_out),
    .y_out          (y_out),
    .gain_pending   (gain_pending),
    .clip_count     (clip_count)
  );

  wb_gain_apply #(
    .CNT_W (4)
  ) u_dut_c4 (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .x              (x),
    .y              (y),
    .frame_start    (frame_start),
    .bk             (bk),
    .rk             (rk),
    .gain_load      (gain_load),
    .data_out_valid (s_valid),
    .data_out       (s_data),
    .x_out          (s_x),
    .y_out          (s_y),
    .gain_pending   (s_pend),
    .clip_count     (s_clip)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_pend(input logic e);
    check_eq("gain_pending", 32'(gain_pending), 32'(e));
    check_eq("c4_gain_pending", 32'(s_pend), 32'(e));
  endtask

  // One clock; the expectation for the input just captured enters a 3-deep latency line.
  task automatic step(input logic e_v, input logic [7:0] e_d, input logic [1:0] e_p);
    @(posedge clk);
    #1;
    for (int i = 2; i > 0; i--) begin
      ev[i] = ev[i-1];
      ed[i] = ed[i-1];
      ep[i] = ep[i-1];
    end
    ev[0] = e_v;
    ed[0] = e_d;
    ep[0] = e_p;
    check_eq("out_valid", 32'(data_out_valid), 32'(ev[2]));
    check_eq("c4_out_valid", 32'(s_valid), 32'(ev[2]));
    if (ev[2]) begin
      check_eq("data_out", 32'(data_out), 32'(ed[2]));
      check_eq("xy_out", 32'({y_out, x_out}), 32'(ep[2]));
      check_eq("c4_data_out", 32'(s_data), 32'(ed[2]));
      check_eq("c4_xy_out", 32'({s_y, s_x}), 32'(ep[2]));
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] ph, input logic fs,
                       input logic gl, input logic [17:0] b, input logic [17:0] r,
                       input logic [7:0] e);
    data_in_valid = v;
    data_in       = d;
    {y, x}        = ph;
    frame_start   = fs;
    gain_load     = gl;
    bk            = b;
    rk            = r;
    step(v, e, ph);
    data_in_valid = 1'b0;
    frame_start   = 1'b0;
    gain_load     = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] d, input logic [1:0] ph, input logic fs,
                       input logic [7:0] e);
    drive(1'b1, d, ph, fs, 1'b0, 18'd0, 18'd0, e);
  endtask

  task automatic load(input logic [17:0] b, input logic [17:0] r);
    drive(1'b0, 8'd0, PB, 1'b0, 1'b1, b, r, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, PB, 1'b0, 1'b0, 18'd0, 18'd0, 8'd0);
  endtask

  task automatic clear_line();
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0;
      ed[i] = '0;
      ep[i] = '0;
    end
  endtask

  initial begin
    data_in_valid = 1'b0;
    data_in       = '0;
    {y, x}        = 2'b00;
    frame_start   = 1'b0;
    gain_load     = 1'b0;
    bk            = '0;
    rk            = '0;
    clear_line();

    #1;
    check_eq("rst_valid", 32'(data_out_valid), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_xy", 32'({y_out, x_out}), 32'd0);
    check_eq("rst_clip", 32'(clip_count), 32'd0);
    check_pend(1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Unity gains after reset
    pixel(8'd100, PB, 1'b0, 8'd100);
    pixel(8'd37, PG0, 1'b0, 8'd37);
    pixel(8'd200, PG1, 1'b0, 8'd200);
    pixel(8'd255, PR, 1'b0, 8'd255);
    idle(3);
    check_eq("clip_unity", 32'(clip_count), 32'd0);

    // bk=2.0, rk=1.5 applied at frame_start on the same pixel; rounding and clipping
    load(18'd512, 18'd384);
    check_pend(1'b1);
    pixel(8'd100, PB, 1'b1, 8'd200);
    check_pend(1'b0);
    pixel(8'd3, PR, 1'b0, 8'd5);
    pixel(8'd200, PR, 1'b0, 8'd255);
    pixel(8'd200, PB, 1'b0, 8'd255);
    pixel(8'd77, PG0, 1'b0, 8'd77);
    idle(3);
    check_eq("clip_first_fs", 32'(clip_count), 32'd0);

    // Load without frame_start keeps old gain until the next frame
    load(18'd1024, 18'd256);
    pixel(8'd20, PB, 1'b0, 8'd40);
    check_pend(1'b1);
    pixel(8'd20, PB, 1'b1, 8'd80);
    check_pend(1'b0);
    idle(3);
    check_eq("clip_frame_a", 32'(clip_count), 32'd2);

    // Load coincident with frame_start: older pending value applies, new one waits
    load(18'd512, 18'd256);
    drive(1'b1, 8'd20, PB, 1'b1, 1'b1, 18'd768, 18'd256, 8'd40);
    check_pend(1'b1);
    pixel(8'd20, PB, 1'b0, 8'd40);
    pixel(8'd20, PB, 1'b1, 8'd60);
    check_pend(1'b0);
    idle(3);
    check_eq("clip_frame_c", 32'(clip_count), 32'd0);

    // Zero gains
    load(18'd0, 18'd0);
    pixel(8'd123, PB, 1'b1, 8'd0);
    pixel(8'd123, PR, 1'b0, 8'd0);
    pixel(8'd123, PG1, 1'b0, 8'd123);
    idle(3);

    // Clip statistics: 10-clip frame, then 20-clip frame ended by an invalid frame_start
    load(18'd512, 18'd256);
    pixel(8'd200, PB, 1'b1, 8'd255);
    repeat (9) pixel(8'd200, PB, 1'b0, 8'd255);
    pixel(8'd10, PG0, 1'b1, 8'd10);
    idle(3);
    check_eq("clip_10", 32'(clip_count), 32'd10);
    check_eq("c4_clip_10", 32'(s_clip), 32'd10);
    repeat (20) pixel(8'd200, PB, 1'b0, 8'd255);
    drive(1'b0, 8'd0, PB, 1'b1, 1'b0, 18'd0, 18'd0, 8'd0);
    idle(3);
    check_eq("clip_20", 32'(clip_count), 32'd20);
    check_eq("c4_clip_sat", 32'(s_clip), 32'd15);

    // Reset with pixels in flight and a pending gain
    load(18'd1024, 18'd1024);
    pixel(8'd50, PB, 1'b0, 8'd0);
    pixel(8'd60, PG0, 1'b0, 8'd0);
    data_in_valid = 1'b1;
    data_in       = 8'd70;
    {y, x}        = PR;
    #1 rst = 1'b1;
    #1;
    data_in_valid = 1'b0;
    clear_line();
    check_eq("mid_rst_valid", 32'(data_out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(data_out), 32'd0);
    check_eq("mid_rst_clip", 32'(clip_count), 32'd0);
    check_pend(1'b0);
    repeat (3) step(1'b0, 8'd0, PB);
    rst = 1'b0;
    idle(3);
    check_eq("post_rst_data", 32'(data_out), 32'd0);
    pixel(8'd100, PB, 1'b1, 8'd100);
    pixel(8'd100, PR, 1'b0, 8'd100);
    idle(3);
    check_pend(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
